// File: rtl/rtc_i2c_writer_pkg.sv
// Shared definitions for the RTC I2C burst writer.
//   state_e        : writer FSM states
//   IDX_*          : byte positions within a burst (address, pointer, seven time bytes)
//   NBYTES         : bytes per burst
//   DEF_DEV_ADDR   : default 7-bit RTC slave address
//   DEF_REG_PTR    : default first register (Seconds)
//   qtick_div()    : system clocks per quarter SCL period
package rtc_i2c_pkg;

   typedef enum logic [2:0] {
      StIdle,
      StStart,
      StBit,
      StAck,
      StStop,
      StDone
   } state_e;

   localparam logic [3:0] IDX_ADDR  = 4'd0;
   localparam logic [3:0] IDX_PTR   = 4'd1;
   localparam logic [3:0] IDX_SEC   = 4'd2;
   localparam logic [3:0] IDX_MIN   = 4'd3;
   localparam logic [3:0] IDX_HOUR  = 4'd4;
   localparam logic [3:0] IDX_DAY   = 4'd5;
   localparam logic [3:0] IDX_DATE  = 4'd6;
   localparam logic [3:0] IDX_MONTH = 4'd7;
   localparam logic [3:0] IDX_YEAR  = 4'd8;
   localparam int unsigned NBYTES   = 9;

   localparam logic [6:0] DEF_DEV_ADDR = 7'h68;
   localparam logic [7:0] DEF_REG_PTR  = 8'h00;

   // Never returns 0 so a too-fast SCL request still yields a working divider.
   function automatic int unsigned qtick_div(input int unsigned clk_freq,
                                             input int unsigned scl_freq);
      int unsigned d;
      d = clk_freq / (4 * scl_freq);
      return (d == 0) ? 1 : d;
   endfunction

endpackage

// File: rtl/rtc_i2c_writer_if.sv
// Request / status / I2C bus bundle of the RTC writer.
//   start              : one-cycle burst request
//   seconds .. year    : time bytes, latched on request acceptance
//   sda_in             : SDA line as seen on the bus
//   scl, sda_out,
//   sda_en             : bus drive (sda_en=1 master drives SDA, 0 releases it)
//   busy, done         : burst in progress / one-cycle completion pulse
//   ack_err,
//   ack_err_idx        : sticky NACK flag and index of the NACKed byte
// Modports: master = the writer, slave = the requester / bus side.
interface rtc_i2c_writer_if;

   logic       start;
   logic [7:0] seconds;
   logic [7:0] minutes;
   logic [7:0] hours;
   logic [7:0] day;
   logic [7:0] date;
   logic [7:0] month;
   logic [7:0] year;
   logic       sda_in;
   logic       scl;
   logic       sda_out;
   logic       sda_en;
   logic       busy;
   logic       done;
   logic       ack_err;
   logic [3:0] ack_err_idx;

   modport master (
      input  start, seconds, minutes, hours, day, date, month, year, sda_in,
      output scl, sda_out, sda_en, busy, done, ack_err, ack_err_idx
   );

   modport slave (
      output start, seconds, minutes, hours, day, date, month, year, sda_in,
      input  scl, sda_out, sda_en, busy, done, ack_err, ack_err_idx
   );

endinterface

// File: rtl/rtc_i2c_writer_qtick_gen.sv
// Quarter-SCL-period tick generator.
//   clk, rst_n : clock, asynchronous active-low reset
//   en         : count while high; counter held at zero while low
//   tick       : one-cycle pulse every DIV clocks after en rises
module i2c_qtick_gen #(
   parameter int unsigned DIV = 125
) (
   input  logic clk,
   input  logic rst_n,
   input  logic en,
   output logic tick
);

   localparam int unsigned CW = (DIV > 1) ? $clog2(DIV) : 1;
   localparam logic [CW-1:0] LAST = CW'(DIV - 1);

   logic [CW-1:0] cnt_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else if (!en || cnt_q == LAST) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_q + 1'b1;
      end
   end

   assign tick = en && (cnt_q == LAST);

endmodule

// File: rtl/rtc_i2c_writer.sv
// Write-only I2C master that loads the RTC time-keeping registers in one burst:
// START, {DEV_ADDR,W}, REG_PTR, seconds..year, STOP, checking ACK after every byte.
// All bus changes happen on quarter-period ticks counted from start acceptance.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : rtc_i2c_writer_if.master (request, time bytes, status, scl/sda)
// Build option: RTC_CH_CLEAR_EN defined -> clock-halt bit (seconds[7]) is cleared
// when latched, so every write also starts the oscillator.
module rtc_i2c_writer
   import rtc_i2c_pkg::*;
#(
   parameter int unsigned CLK_FREQ = 50_000_000,
   parameter int unsigned SCL_FREQ = 100_000,
   parameter logic [6:0]  DEV_ADDR = DEF_DEV_ADDR,
   parameter logic [7:0]  REG_PTR  = DEF_REG_PTR
) (
   input logic              clk,
   input logic              rst_n,
   rtc_i2c_writer_if.master bus
);

   localparam int unsigned DIV = qtick_div(CLK_FREQ, SCL_FREQ);

   state_e          state_q;
   logic [1:0]      qtr_q;
   logic [2:0]      bit_q;
   logic [3:0]      idx_q;
   logic [7:0]      sh_q;
   logic [6:0][7:0] time_q;

   logic       scl_q;
   logic       sda_out_q;
   logic       sda_en_q;
   logic       busy_q;
   logic       done_q;
   logic       ack_err_q;
   logic [3:0] ack_idx_q;

   logic       tick;
   logic [3:0] idx_nxt;
   logic [7:0] byte_nxt;

   // Divider runs only while busy, so ticks are phased from the acceptance cycle.
   i2c_qtick_gen #(
      .DIV (DIV)
   ) u_qtick (
      .clk   (clk),
      .rst_n (rst_n),
      .en    (busy_q),
      .tick  (tick)
   );

   assign idx_nxt = idx_q + 4'd1;

   // Byte that follows the current one; the address byte is loaded directly in START.
   always_comb begin
      byte_nxt = 8'h00;
      case (idx_nxt)
         IDX_PTR:   byte_nxt = REG_PTR;
         IDX_SEC:   byte_nxt = time_q[0];
         IDX_MIN:   byte_nxt = time_q[1];
         IDX_HOUR:  byte_nxt = time_q[2];
         IDX_DAY:   byte_nxt = time_q[3];
         IDX_DATE:  byte_nxt = time_q[4];
         IDX_MONTH: byte_nxt = time_q[5];
         IDX_YEAR:  byte_nxt = time_q[6];
         default:   byte_nxt = 8'h00;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= StIdle;
         qtr_q     <= 2'd0;
         bit_q     <= 3'd0;
         idx_q     <= IDX_ADDR;
         sh_q      <= 8'h00;
         time_q    <= '0;
         scl_q     <= 1'b1;
         sda_out_q <= 1'b1;
         sda_en_q  <= 1'b0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         ack_err_q <= 1'b0;
         ack_idx_q <= 4'd0;
      end else begin
         done_q <= 1'b0;
         unique case (state_q)
            StIdle: begin
               if (bus.start) begin
`ifdef RTC_CH_CLEAR_EN
                  time_q[0] <= {1'b0, bus.seconds[6:0]};
`else
                  time_q[0] <= bus.seconds;
`endif
                  time_q[1] <= bus.minutes;
                  time_q[2] <= bus.hours;
                  time_q[3] <= bus.day;
                  time_q[4] <= bus.date;
                  time_q[5] <= bus.month;
                  time_q[6] <= bus.year;
                  busy_q    <= 1'b1;
                  ack_err_q <= 1'b0;
                  ack_idx_q <= 4'd0;
                  idx_q     <= IDX_ADDR;
                  qtr_q     <= 2'd0;
                  state_q   <= StStart;
               end
            end

            StStart: begin
               if (tick) begin
                  if (qtr_q == 2'd0) begin
                     scl_q     <= 1'b1;
                     sda_en_q  <= 1'b1;
                     sda_out_q <= 1'b1;
                     qtr_q     <= 2'd1;
                  end else begin
                     // SDA falls while SCL is high: START condition.
                     sda_out_q <= 1'b0;
                     qtr_q     <= 2'd0;
                     bit_q     <= 3'd7;
                     sh_q      <= {DEV_ADDR, 1'b0};
                     state_q   <= StBit;
                  end
               end
            end

            StBit: begin
               if (tick) begin
                  qtr_q <= qtr_q + 2'd1;
                  unique case (qtr_q)
                     2'd0: begin
                        scl_q     <= 1'b0;
                        sda_en_q  <= 1'b1;
                        sda_out_q <= sh_q[7];
                     end
                     2'd1: scl_q <= 1'b1;
                     2'd2: scl_q <= 1'b1;
                     2'd3: begin
                        scl_q <= 1'b0;
                        sh_q  <= {sh_q[6:0], 1'b0};
                        if (bit_q == 3'd0) begin
                           state_q <= StAck;
                        end else begin
                           bit_q <= bit_q - 3'd1;
                        end
                     end
                     default: scl_q <= 1'b0;
                  endcase
               end
            end

            StAck: begin
               if (tick) begin
                  qtr_q <= qtr_q + 2'd1;
                  unique case (qtr_q)
                     2'd0: begin
                        scl_q    <= 1'b0;
                        sda_en_q <= 1'b0;
                     end
                     2'd1: scl_q <= 1'b1;
                     2'd2: begin
                        // Mid-high sample: a released (high) line is a NACK.
                        if (bus.sda_in) begin
                           ack_err_q <= 1'b1;
                           ack_idx_q <= idx_q;
                        end
                     end
                     2'd3: begin
                        scl_q <= 1'b0;
                        // ack_err_q was cleared at acceptance, so it reflects this burst only.
                        if (ack_err_q || idx_q == IDX_YEAR) begin
                           state_q <= StStop;
                        end else begin
                           idx_q   <= idx_nxt;
                           sh_q    <= byte_nxt;
                           bit_q   <= 3'd7;
                           state_q <= StBit;
                        end
                     end
                     default: scl_q <= 1'b0;
                  endcase
               end
            end

            StStop: begin
               if (tick) begin
                  if (qtr_q == 2'd0) begin
                     scl_q     <= 1'b0;
                     sda_en_q  <= 1'b1;
                     sda_out_q <= 1'b0;
                     qtr_q     <= 2'd1;
                  end else if (qtr_q == 2'd1) begin
                     scl_q <= 1'b1;
                     qtr_q <= 2'd2;
                  end else begin
                     // SDA rises while SCL is high: STOP, then the line is released.
                     sda_out_q <= 1'b1;
                     sda_en_q  <= 1'b0;
                     busy_q    <= 1'b0;
                     done_q    <= 1'b1;
                     qtr_q     <= 2'd0;
                     state_q   <= StDone;
                  end
               end
            end

            // One-cycle gap so a start coincident with done is not accepted.
            StDone: state_q <= StIdle;

            default: state_q <= StIdle;
         endcase
      end
   end

   assign bus.scl         = scl_q;
   assign bus.sda_out     = sda_out_q;
   assign bus.sda_en      = sda_en_q;
   assign bus.busy        = busy_q;
   assign bus.done        = done_q;
   assign bus.ack_err     = ack_err_q;
   assign bus.ack_err_idx = ack_idx_q;

endmodule

// File: tb/tb_rtc_i2c_writer.sv
// Bench for rtc_i2c_writer: a bus-level slave decodes START/bytes/ACK/STOP from the
// scl/sda lines, ACKs according to a per-burst plan, and results are compared with
// expectations from a table and from a burst-level model.
module tb_rtc_i2c_writer;

   localparam int unsigned CLK_FREQ = 1_600_000;
   localparam int unsigned SCL_FREQ = 100_000;
   localparam int unsigned DIV      = CLK_FREQ / (4 * SCL_FREQ);
   localparam int unsigned FULL_Q   = 2 + 9 * 36 + 3;

   typedef struct {
      string       name;
      logic [55:0] b;       // {year,month,date,day,hours,minutes,seconds}
      logic [8:0]  plan;    // bit i = slave ACKs byte i
      logic        exp_err;
      logic [3:0]  exp_idx;
      int          exp_n;   // bytes that appear on the bus
   } vec_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   rtc_i2c_writer_if bus_if ();

   rtc_i2c_writer #(
      .CLK_FREQ (CLK_FREQ),
      .SCL_FREQ (SCL_FREQ),
      .DEV_ADDR (7'h68),
      .REG_PTR  (8'h00)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus_if)
   );

   int checks = 0;
   int failures = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
      end
   endtask

   // ---------------- slave / bus monitor ----------------
   logic       pull = 1'b0;
   logic [8:0] ack_plan = 9'h1FF;
   logic       line;
   logic       prev_scl = 1'b1;
   logic       prev_line = 1'b1;
   logic [7:0] shreg = 8'h00;
   int         bitcnt = 0;
   int         byte_idx = 0;
   int         n_start = 0;
   int         n_stop = 0;
   logic [7:0] got_bytes[$];
   logic       got_acks[$];

   assign line = (bus_if.sda_en ? bus_if.sda_out : 1'b1) & ~pull;
   assign bus_if.sda_in = line;

   always @(negedge clk) begin
      if (!rst_n) begin
         pull      <= 1'b0;
         bitcnt    <= 0;
         byte_idx  <= 0;
         prev_scl  <= 1'b1;
         prev_line <= 1'b1;
      end else begin
         prev_scl  <= bus_if.scl;
         prev_line <= line;
         if (prev_scl && bus_if.scl && prev_line && !line) begin
            n_start  <= n_start + 1;
            bitcnt   <= 0;
            byte_idx <= 0;
         end else if (prev_scl && bus_if.scl && !prev_line && line) begin
            n_stop <= n_stop + 1;
         end else if (!prev_scl && bus_if.scl) begin
            if (bitcnt < 8) begin
               shreg  <= {shreg[6:0], line};
               bitcnt <= bitcnt + 1;
            end else begin
               got_bytes.push_back(shreg);
               got_acks.push_back(~line);
               bitcnt   <= 0;
               byte_idx <= byte_idx + 1;
            end
         end else if (prev_scl && !bus_if.scl) begin
            pull <= (bitcnt == 8) && (byte_idx < 9) && ack_plan[byte_idx];
         end
      end
   end

   // ---------------- reference model ----------------
   function automatic vec_t model_vec(input string nm, input logic [55:0] b, input logic [8:0] plan);
      vec_t v;
      v.name = nm; v.b = b; v.plan = plan;
      v.exp_err = 1'b0; v.exp_idx = 4'd0; v.exp_n = 9;
      for (int i = 8; i >= 0; i--) begin
         if (!plan[i]) begin
            v.exp_err = 1'b1; v.exp_idx = 4'(i); v.exp_n = i + 1;
         end
      end
      return v;
   endfunction

   function automatic logic [7:0] exp_byte(input logic [55:0] b, input int i);
      logic [7:0] r;
      if (i == 0) r = 8'hD0;
      else if (i == 1) r = 8'h00;
      else r = b[(i-2)*8 +: 8];
`ifdef RTC_CH_CLEAR_EN
      if (i == 2) r[7] = 1'b0;
`endif
      return r;
   endfunction

   function automatic vec_t mk(input string nm, input logic [55:0] b, input logic [8:0] plan,
                               input logic err, input logic [3:0] idx, input int n);
      vec_t v;
      v.name = nm; v.b = b; v.plan = plan; v.exp_err = err; v.exp_idx = idx; v.exp_n = n;
      return v;
   endfunction

   task automatic set_bytes(input logic [55:0] b);
      bus_if.seconds = b[7:0];   bus_if.minutes = b[15:8];  bus_if.hours = b[23:16];
      bus_if.day     = b[31:24]; bus_if.date    = b[39:32]; bus_if.month = b[47:40];
      bus_if.year    = b[55:48];
   endtask

   // mid_cyc > 0: pulse start (with different data) that many clocks into the burst.
   task automatic run_burst(input vec_t v, input int mid_cyc, input bit done_pulse);
      int cyc;
      int limit;
      int st0;
      int sp0;
      bit seen;
      @(posedge clk);
      #1;
      ack_plan = v.plan;
      got_bytes.delete();
      got_acks.delete();
      st0 = n_start;
      sp0 = n_stop;
      @(negedge clk);
      set_bytes(v.b);
      bus_if.start = 1'b1;
      @(posedge clk);
      @(negedge clk);
      bus_if.start = 1'b0;
      set_bytes(~v.b);
      check({v.name, ".busy_on_accept"}, 32'(bus_if.busy), 32'd1);
      check({v.name, ".ack_err_cleared"}, 32'(bus_if.ack_err), 32'd0);
      cyc = 0;
      seen = 1'b0;
      limit = FULL_Q * DIV + 20;
      while (cyc < limit && !seen) begin
         @(posedge clk);
         cyc++;
         @(negedge clk);
         if (bus_if.done) begin
            seen = 1'b1;
            bus_if.start = done_pulse;
         end else begin
            bus_if.start = (mid_cyc > 0 && cyc == mid_cyc);
         end
      end
      check({v.name, ".done_seen"}, 32'(seen), 32'd1);
      check({v.name, ".latency"}, 32'(cyc), 32'((5 + 36 * v.exp_n) * DIV));
      check({v.name, ".busy_at_done"}, 32'(bus_if.busy), 32'd0);
      check({v.name, ".ack_err"}, 32'(bus_if.ack_err), 32'(v.exp_err));
      check({v.name, ".ack_err_idx"}, 32'(bus_if.ack_err_idx), 32'(v.exp_idx));
      check({v.name, ".scl_idle"}, 32'(bus_if.scl), 32'd1);
      check({v.name, ".sda_released"}, 32'(bus_if.sda_en), 32'd0);
      @(posedge clk);
      @(negedge clk);
      bus_if.start = 1'b0;
      check({v.name, ".done_one_cycle"}, 32'(bus_if.done), 32'd0);
      check({v.name, ".no_restart"}, 32'(bus_if.busy), 32'd0);
      check({v.name, ".ack_err_sticky"}, 32'(bus_if.ack_err), 32'(v.exp_err));
      check({v.name, ".nbytes"}, 32'(got_bytes.size()), 32'(v.exp_n));
      for (int i = 0; i < v.exp_n && i < got_bytes.size(); i++) begin
         check($sformatf("%s.byte%0d", v.name, i), 32'(got_bytes[i]), 32'(exp_byte(v.b, i)));
         check($sformatf("%s.ack%0d", v.name, i), 32'(got_acks[i]), 32'(v.plan[i]));
      end
      check({v.name, ".starts"}, 32'(n_start - st0), 32'd1);
      check({v.name, ".stops"}, 32'(n_stop - sp0), 32'd1);
   endtask

   vec_t vecs[6];

   initial begin
      bus_if.start = 1'b0;
      set_bytes(56'h0);
      vecs[0] = mk("full_ack",   56'h24_12_25_03_12_45_30, 9'h1FF, 1'b0, 4'd0, 9);
      vecs[1] = mk("nack_addr",  56'h24_12_25_03_12_45_30, 9'h000, 1'b1, 4'd0, 1);
      vecs[2] = mk("nack_month", 56'h99_11_31_07_23_59_58, 9'h17F, 1'b1, 4'd7, 8);
      vecs[3] = mk("ch_bit",     56'h24_12_25_03_12_45_B0, 9'h1FF, 1'b0, 4'd0, 9);
      vecs[4] = mk("nack_ptr",   56'h01_02_03_04_05_06_07, 9'h1FD, 1'b1, 4'd1, 2);
      vecs[5] = mk("nack_year",  56'h55_AA_55_AA_55_AA_55, 9'h0FF, 1'b1, 4'd8, 9);

      // Start held during reset must not be accepted.
      #2 bus_if.start = 1'b1;
      repeat (3) @(negedge clk);
      check("rst.scl", 32'(bus_if.scl), 32'd1);
      check("rst.sda_out", 32'(bus_if.sda_out), 32'd1);
      check("rst.sda_en", 32'(bus_if.sda_en), 32'd0);
      check("rst.busy", 32'(bus_if.busy), 32'd0);
      check("rst.done", 32'(bus_if.done), 32'd0);
      check("rst.ack_err", 32'(bus_if.ack_err), 32'd0);
      check("rst.ack_err_idx", 32'(bus_if.ack_err_idx), 32'd0);
      bus_if.start = 1'b0;
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
      check("rst.start_ignored", 32'(bus_if.busy), 32'd0);

      foreach (vecs[i]) run_burst(vecs[i], 0, 1'b0);

      // Start mid-burst and in the done cycle: both ignored.
      run_burst(vecs[0], 37 * DIV + 2, 1'b1);

      // Reset during bit 3 (q0, scl low) of the minutes byte.
      @(posedge clk);
      #1 ack_plan = 9'h1FF;
      @(negedge clk);
      set_bytes(vecs[0].b);
      bus_if.start = 1'b1;
      @(posedge clk);
      @(negedge clk);
      bus_if.start = 1'b0;
      repeat (123 * DIV) @(posedge clk);
      @(negedge clk);
      check("midrst.scl_low_before", 32'(bus_if.scl), 32'd0);
      check("midrst.driving_before", 32'(bus_if.sda_en), 32'd1);
      rst_n = 1'b0;
      bus_if.start = 1'b1;
      #1;
      check("midrst.scl", 32'(bus_if.scl), 32'd1);
      check("midrst.sda_en", 32'(bus_if.sda_en), 32'd0);
      check("midrst.busy", 32'(bus_if.busy), 32'd0);
      check("midrst.sda_out", 32'(bus_if.sda_out), 32'd1);
      @(negedge clk);
      bus_if.start = 1'b0;
      rst_n = 1'b1;
      repeat (DIV + 2) @(negedge clk);
      check("midrst.idle_after", 32'(bus_if.scl), 32'd1);
      check("midrst.not_busy", 32'(bus_if.busy), 32'd0);
      run_burst(vecs[0], 0, 1'b0);

      // Randomized bursts against the model.
      for (int r = 0; r < 4; r++) begin
         logic [55:0] b;
         logic [8:0]  plan;
         b = {$urandom(), $urandom()};
         if ($urandom_range(0, 1) == 0) plan = 9'h1FF;
         else plan = 9'h1FF & ~(9'h1 << $urandom_range(0, 8));
         run_burst(model_vec($sformatf("rand%0d", r), b, plan), 0, 1'b0);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/rtc_i2c_writer.md
Name: rtc_i2c_writer

Overview:
- I2C master, write-only; sets the RTC time-keeping registers.
- On a start pulse it latches seven BCD time bytes and issues one burst write: START, device address + W, register pointer 0x00, Seconds..Year, STOP.
- Checks the slave ACK after every byte.
- Drives the same scl/sda/sda_en bus that the time-capture logic monitors. sda_en=1 means the master drives SDA; sda_en=0 means SDA is released.

Parameters:
- CLK_FREQ, 50_000_000: system clock frequency in Hz.
- SCL_FREQ, 100_000: target SCL frequency in Hz.
- DEV_ADDR, 7'h68: 7-bit RTC slave address.
- REG_PTR, 8'h00: first register written (Seconds).

Ports:
- clk  in  1  system clock; all logic is on its rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle request to begin a write burst.
- seconds  in  8  BCD seconds.
- minutes  in  8  BCD minutes.
- hours  in  8  BCD hours.
- day  in  8  day of week.
- date  in  8  BCD date.
- month  in  8  BCD month.
- year  in  8  BCD year.
- sda_in  in  1  SDA line value as seen on the bus.
- scl  out  1  I2C clock.
- sda_out  out  1  SDA value, valid only when sda_en=1.
- sda_en  out  1  1 = master drives SDA; 0 = released.
- busy  out  1  high from start acceptance until the done cycle.
- done  out  1  one-cycle pulse at the end of every burst.
- ack_err  out  1  sticky NACK flag for the last burst.
- ack_err_idx  out  4  index of the NACKed byte: 0 = address, 1 = pointer, 2..8 = data.

Behaviour:
- Reset values, applied immediately and asynchronously, including mid-burst:
  - scl=1, sda_out=1, sda_en=0.
  - busy=0, done=0, ack_err=0, ack_err_idx=0.
  - All internal state returns to IDLE; divider and counters are cleared.
- Quarter tick:
  - DIV = CLK_FREQ/(4*SCL_FREQ) = 125 with defaults.
  - The tick is a one-cycle pulse every DIV clocks, counted from start acceptance.
  - All bus changes occur only on ticks.
- start handling:
  - start is sampled only in IDLE; it is ignored while busy=1.
  - On acceptance: latch all seven bytes, set busy=1, clear ack_err and ack_err_idx.
- Byte order: 9 bytes total, each sent MSB first.
  - {DEV_ADDR,1'b0} = 8'hD0, then REG_PTR, then seconds, minutes, hours, day, date, month, year.
- State machine: IDLE -> START -> BIT -> ACK -> (BIT | STOP) -> DONE -> IDLE.
- START, 2 quarters:
  - q0: scl=1, sda_en=1, sda_out=1.
  - q1: scl=1, sda_out=0.
- BIT, 4 quarters per bit:
  - q0: scl=0; sda_out takes the next bit.
  - q1, q2: scl=1.
  - q3: scl=0.
  - SDA changes only while scl=0.
- ACK, 4 quarters, same scl pattern as BIT:
  - sda_en=0 for the whole slot.
  - sda_in is sampled on the q2 tick; 0 = ACK.
  - On ACK after byte 8: go to STOP. Otherwise go to BIT for the next byte.
- NACK:
  - ack_err=1 and ack_err_idx = current byte index.
  - Go directly to STOP; no further bytes are sent.
- STOP, 3 quarters:
  - q0: scl=0, sda_en=1, sda_out=0.
  - q1: scl=1.
  - q2: sda_out=1, then sda_en=0.
- DONE:
  - done=1 for exactly one clk; busy drops in the same cycle.
- Latency:
  - Full burst = 2 + 9*36 + 3 = 329 quarters.
  - done is asserted 329*DIV clocks after the acceptance cycle.
  - A NACK shortens the burst accordingly.
- start asserted in the done cycle is ignored; it is accepted from the following cycle onward.
- A start pulse during reset is ignored.

Optional Feature:
- Macro: RTC_CH_CLEAR_EN.
- Defined: bit 7 of the latched seconds byte (clock-halt) is forced to 0, so every write starts the oscillator.
- Undefined: seconds is transmitted exactly as given.

Decomposition:
- Shared package rtc_i2c_pkg holds:
  - State enum.
  - Byte-index constants: IDX_ADDR=0, IDX_PTR=1, IDX_SEC=2 .. IDX_YEAR=8, NBYTES=9.
  - Default device address and register pointer.
- One sub-module, i2c_qtick_gen:
  - Parameterised divider producing the quarter tick.
  - Has an enable input; the counter restarts when enable is low.

Test Plan:
- Full burst, slave ACKs every byte; start with 8'h30,8'h45,8'h12,8'h03,8'h25,8'h12,8'h24 -> bus decodes to D0,00,30,45,12,03,25,12,24; done after 329*125 clocks; ack_err=0.
- NACK on the address byte (sda_in held 1) -> ack_err=1, ack_err_idx=0, STOP follows the first ACK slot, done pulses, scl and sda return to 1.
- NACK on the month byte only -> ack_err_idx=7, year is never sent.
- start pulsed mid-burst, and again in the done cycle -> both ignored; the burst is unchanged.
- rst_n low during data bit 3 of minutes -> scl=1 and sda_en=0 immediately; a new start after release produces a clean full burst.
- RTC_CH_CLEAR_EN defined, seconds=8'hB0 -> 8'h30 on the bus; undefined -> 8'hB0.
